// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Brief    : Walks a register-file address range through one read port and
//            streams each snapshotted word out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] lo_addr,
    input  logic [ADDR_WIDTH-1:0] hi_addr,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   cur_q,       cur_d;
    logic [ADDR_WIDTH-1:0]   hi_q,        hi_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;
    logic [ADDR_WIDTH:0]     word_cnt_q,  word_cnt_d;
    logic [ADDR_WIDTH-1:0]   hi_clamped;

    always_comb begin
        hi_clamped  = (hi_addr > LAST_REG) ? LAST_REG : hi_addr;
        state_d     = state_q;
        cur_d       = cur_q;
        hi_d        = hi_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        word_cnt_d  = word_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_d       = hi_clamped;
                    word_cnt_d = '0;
                    // Empty range leaves cur (and so rf_addr) untouched, which
                    // also keeps an out-of-range lo_addr off the read port.
                    if (lo_addr > hi_clamped) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = lo_addr;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                out_data_d  = rf_data;
                out_addr_d  = cur_q;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    word_cnt_d  = word_cnt_q + 1'b1;
                    out_valid_d = 1'b0;
                    if (cur_q == hi_q) begin
                        state_d = S_DONE;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags describe the state being entered so they come out registered.
        busy_d = (state_d == S_READ) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            hi_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hi_q        <= hi_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign rf_addr   = cur_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign word_cnt  = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Brief    : Self-checking bench for regfile_dump_reader (32- and 16-entry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        CLK;
    logic        rst;
    logic        start_cmd;
    logic        use16;
    logic [4:0]  lo_addr;
    logic [4:0]  hi_addr;
    logic        out_ready;
    logic [31:0] regs [32];

    logic        start,     start16;
    logic [4:0]  rf_addr,   rf_addr16;
    logic [31:0] rf_data,   rf_data16;
    logic        out_valid, out_valid16;
    logic [31:0] out_data,  out_data16;
    logic [4:0]  out_addr,  out_addr16;
    logic        busy,      busy16;
    logic        done,      done16;
    logic [5:0]  word_cnt,  word_cnt16;

    logic        v_valid, v_busy, v_done;
    logic [31:0] v_data;
    logic [4:0]  v_addr, v_rf_addr;
    logic [5:0]  v_cnt;

    int total = 0;
    int bad   = 0;

    assign start     = start_cmd & ~use16;
    assign start16   = start_cmd &  use16;
    assign rf_data   = regs[rf_addr];
    assign rf_data16 = regs[rf_addr16];

    assign v_valid   = use16 ? out_valid16 : out_valid;
    assign v_busy    = use16 ? busy16      : busy;
    assign v_done    = use16 ? done16      : done;
    assign v_data    = use16 ? out_data16  : out_data;
    assign v_addr    = use16 ? out_addr16  : out_addr;
    assign v_rf_addr = use16 ? rf_addr16   : rf_addr;
    assign v_cnt     = use16 ? word_cnt16  : word_cnt;

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32)) dut (
        .CLK(CLK), .rst(rst), .start(start), .lo_addr(lo_addr), .hi_addr(hi_addr),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    regfile_dump_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(16)) dut16 (
        .CLK(CLK), .rst(rst), .start(start16), .lo_addr(lo_addr), .hi_addr(hi_addr),
        .rf_addr(rf_addr16), .rf_data(rf_data16), .out_valid(out_valid16), .out_ready(out_ready),
        .out_data(out_data16), .out_addr(out_addr16), .busy(busy16), .done(done16),
        .word_cnt(word_cnt16)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference: the dump is the list of (addr, value) for lo..min(hi, rc-1),
    // values taken at start; each word costs one READ cycle plus its HOLD cycles.
    task automatic do_dump(input int lo, input int hi, input int ready_pct, input string tag);
        int          exp_addr[$];
        logic [31:0] exp_data[$];
        int          rc, hc, n, k, cyc;
        bit          in_read;
        rc = use16 ? 16 : 32;
        hc = (hi > rc - 1) ? rc - 1 : hi;
        for (int a = lo; a <= hc; a++) begin
            exp_addr.push_back(a);
            exp_data.push_back(regs[a]);
        end
        n = exp_addr.size();
        lo_addr   = lo[4:0];
        hi_addr   = hi[4:0];
        out_ready = 1'b0;
        start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        if (n == 0) begin
            chk({tag, "_empty_done"},  64'(v_done),  64'd1);
            chk({tag, "_empty_valid"}, 64'(v_valid), 64'd0);
            chk({tag, "_empty_busy"},  64'(v_busy),  64'd0);
            chk({tag, "_empty_cnt"},   64'(v_cnt),   64'd0);
            tick();
            chk({tag, "_empty_done_off"}, 64'(v_done),  64'd0);
            chk({tag, "_empty_valid2"},   64'(v_valid), 64'd0);
        end else begin
            k = 0; cyc = 0; in_read = 1'b1;
            while (k < n && cyc < 1000) begin
                chk({tag, "_busy"}, 64'(v_busy), 64'd1);
                chk({tag, "_done_low"}, 64'(v_done), 64'd0);
                if (in_read) begin
                    chk({tag, "_read_valid"}, 64'(v_valid),   64'd0);
                    chk({tag, "_rf_addr"},    64'(v_rf_addr), 64'(exp_addr[k]));
                    out_ready = ($urandom_range(99, 0) < ready_pct);
                    in_read   = 1'b0;
                end else begin
                    chk({tag, "_hold_valid"}, 64'(v_valid), 64'd1);
                    chk({tag, "_out_addr"},   64'(v_addr),  64'(exp_addr[k]));
                    chk({tag, "_out_data"},   64'(v_data),  64'(exp_data[k]));
                    chk({tag, "_mid_cnt"},    64'(v_cnt),   64'(k));
                    out_ready = ($urandom_range(99, 0) < ready_pct);
                    if (out_ready) begin
                        k++;
                        in_read = 1'b1;
                    end
                end
                tick();
                cyc++;
            end
            out_ready = 1'b0;
            chk({tag, "_progress"},   64'(k),       64'(n));
            chk({tag, "_done"},       64'(v_done),  64'd1);
            chk({tag, "_end_busy"},   64'(v_busy),  64'd0);
            chk({tag, "_end_valid"},  64'(v_valid), 64'd0);
            chk({tag, "_word_cnt"},   64'(v_cnt),   64'(n));
            tick();
            chk({tag, "_done_off"},   64'(v_done),  64'd0);
            chk({tag, "_cnt_hold"},   64'(v_cnt),   64'(n));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rf_addr"},  64'(rf_addr),   64'd0);
        chk({tag, "_valid"},    64'(out_valid), 64'd0);
        chk({tag, "_data"},     64'(out_data),  64'd0);
        chk({tag, "_addr"},     64'(out_addr),  64'd0);
        chk({tag, "_busy"},     64'(busy),      64'd0);
        chk({tag, "_done"},     64'(done),      64'd0);
        chk({tag, "_word_cnt"}, 64'(word_cnt),  64'd0);
    endtask

    initial begin
        use16     = 1'b0;
        start_cmd = 1'b0;
        lo_addr   = '0;
        hi_addr   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        for (int a = 0; a < 32; a++) regs[a] = 32'd0;

        // Reset held two cycles under random input activity.
        for (int i = 0; i < 2; i++) begin
            start_cmd = 1'($urandom);
            lo_addr   = 5'($urandom);
            hi_addr   = 5'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk_reset_outputs("reset");
            chk("reset_valid16", 64'(out_valid16), 64'd0);
            chk("reset_busy16",  64'(busy16),      64'd0);
            chk("reset_done16",  64'(done16),      64'd0);
        end
        start_cmd = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Range dump with an always-ready sink.
        regs[5] = 32'd6;
        regs[9] = 32'h2004;
        do_dump(4, 9, 100, "range");

        // Backpressure with a write to the held register during the stall.
        lo_addr = 5'd5; hi_addr = 5'd5; out_ready = 1'b0; start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        chk("bp_read_rf_addr", 64'(rf_addr),   64'd5);
        chk("bp_read_valid",   64'(out_valid), 64'd0);
        tick();
        for (int i = 0; i <= 10; i++) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data",  64'(out_data),  64'd6);
            chk("bp_addr",  64'(out_addr),  64'd5);
            chk("bp_done",  64'(done),      64'd0);
            if (i == 3) regs[5] = 32'h55;
            out_ready = (i == 10);
            tick();
        end
        out_ready = 1'b0;
        chk("bp_done_pulse", 64'(done),      64'd1);
        chk("bp_valid_off",  64'(out_valid), 64'd0);
        chk("bp_word_cnt",   64'(word_cnt),  64'd1);
        tick();
        chk("bp_done_off",   64'(done),      64'd0);

        // Boundaries.
        do_dump(10, 3, 100, "inverted");
        do_dump(30, 31, 70, "top_pair");
        use16 = 1'b1;
        do_dump(12, 31, 100, "clamp16");
        do_dump(20, 31, 100, "lo_oob16");
        use16 = 1'b0;

        // Start while busy is ignored; reset mid-dump drops the word silently.
        for (int a = 1; a < 32; a++) regs[a] = $urandom;
        lo_addr = 5'd0; hi_addr = 5'd31; out_ready = 1'b1; start_cmd = 1'b1;
        tick();
        start_cmd = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            chk("mid_read_rf_addr", 64'(rf_addr),   64'(k));
            chk("mid_read_valid",   64'(out_valid), 64'd0);
            out_ready = 1'b1;
            tick();
            chk("mid_hold_addr", 64'(out_addr), 64'(k));
            chk("mid_hold_data", 64'(out_data), 64'(regs[k]));
            chk("mid_hold_cnt",  64'(word_cnt), 64'(k));
            if (k == 3) begin
                start_cmd = 1'b1; lo_addr = 5'd7; hi_addr = 5'd8;
            end
            if (k == 5) begin
                rst = 1'b1; out_ready = 1'b0;
            end
            tick();
            start_cmd = 1'b0;
        end
        rst = 1'b0;
        chk_reset_outputs("midrst");
        tick();
        chk("midrst_done_after", 64'(done), 64'd0);
        chk("midrst_busy_after", 64'(busy), 64'd0);
        do_dump(0, 0, 100, "single_x0");

        // Randomized dumps on both instances.
        for (int it = 0; it < 12; it++) begin
            int lo_r, hi_r, pct;
            use16 = it[0];
            for (int a = 1; a < 32; a++) regs[a] = $urandom;
            lo_r = $urandom_range(31, 0);
            hi_r = $urandom_range(31, 0);
            pct  = $urandom_range(100, 25);
            do_dump(lo_r, hi_r, pct, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
